// File: rtl/glb_read_sink_pkg.sv
// Shared definitions for the GLB stream receive sink: word width, FSM states
// and the stall LFSR seed/feedback.
package glb_read_sink_pkg;

    localparam int          GLB_DATA_W = 17;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_HDR   = 3'd2,
        ST_PAY   = 3'd3,
        ST_DONE  = 3'd4
    } glb_state_e;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1
    function automatic logic lfsr_feedback(input logic [15:0] s);
        return s[15] ^ s[13] ^ s[12] ^ s[10];
    endfunction

    function automatic logic is_active(input glb_state_e s);
        return (s == ST_HDR) || (s == ST_PAY);
    endfunction

endpackage

// File: rtl/glb_read_sink_if.sv
// Ready/valid stream bundle carried from the producing tile into the sink.
interface glb_read_sink_if #(
    parameter int DATA_W = 17
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/glb_read_sink_stall_lfsr.sv
// Free-running 16-bit LFSR; any set bit under the mask requests a stall.
module glb_stall_lfsr
    import glb_read_sink_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] mask,
    output logic        stall
);

    logic [15:0] lfsr_r;

    // shift register advance
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= LFSR_SEED;
        end else if (en) begin
            lfsr_r <= {lfsr_r[14:0], lfsr_feedback(lfsr_r)};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign stall = |(lfsr_r & mask);

endmodule

// File: rtl/glb_read_sink.sv
// Receive end of the GLB stream: parses length-prefixed segments, captures every
// accepted word into local RAM and exposes it through a registered readback port.
module glb_read_sink
    import glb_read_sink_pkg::*;
#(
    parameter int DATA_W    = GLB_DATA_W,
    parameter int DEPTH     = 2048,
    parameter int TX_NUM    = 1,
    parameter int STALL_EN  = 0,
    parameter int RAN_SHIFT = 0,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    glb_read_sink_if.slave    strm,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count,
    output logic [15:0]       seg_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W+1)'(DEPTH);
    localparam logic [15:0]     STALL_MASK = 16'(2'b11) << RAN_SHIFT;
    localparam logic            STALL_ON   = (STALL_EN != 0);

    glb_state_e        state_r, state_nx_s;
    logic [ADDR_W:0]   word_count_r, word_count_nx_s;
    logic [15:0]       seg_count_r, seg_count_nx_s;
    logic [15:0]       remain_r, remain_nx_s;
    logic              ready_r, ready_nx_s;
    logic              done_r, done_nx_s;
    logic              overflow_r, overflow_nx_s;
    logic [DATA_W-1:0] rd_data_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic lfsr_stall_s, stall_s, active_s, full_s, xfer_s, we_s;
    logic seg_last_s, seg_done_s, last_seg_s;

    glb_stall_lfsr u_stall (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .mask  (STALL_MASK),
        .stall (lfsr_stall_s)
    );

    assign stall_s    = STALL_ON & lfsr_stall_s;
    assign active_s   = is_active(state_r);
    assign full_s     = (word_count_r == DEPTH_C);
    assign xfer_s     = strm.valid & ready_r & active_s & ~full_s;
    assign seg_last_s = (state_r == ST_HDR) ? (strm.data[15:0] == 16'd0)
                                            : (remain_r == 16'd1);
    assign seg_done_s = xfer_s & seg_last_s;
    assign last_seg_s = ((seg_count_r + 16'd1) == 16'(TX_NUM));

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // next-state decode; flush overrides every state
    always_comb begin
        state_nx_s = state_r;
        if (flush) begin
            state_nx_s = ST_FLUSH;
        end else begin
            case (state_r)
                ST_IDLE:  state_nx_s = ST_IDLE;
                ST_FLUSH: state_nx_s = ST_HDR;
                ST_HDR, ST_PAY: begin
                    if (full_s) begin
                        state_nx_s = ST_DONE;
                    end else if (seg_done_s) begin
                        state_nx_s = last_seg_s ? ST_DONE : ST_HDR;
                    end else if (xfer_s) begin
                        state_nx_s = ST_PAY;
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                ST_DONE:  state_nx_s = ST_DONE;
                default:  state_nx_s = ST_IDLE;
            endcase
        end
    end

    // datapath/output next values; ready lags entry into HDR but drops on exit
    always_comb begin
        we_s            = xfer_s & ~flush;
        word_count_nx_s = word_count_r;
        seg_count_nx_s  = seg_count_r;
        remain_nx_s     = remain_r;
        overflow_nx_s   = overflow_r;
        if (flush) begin
            word_count_nx_s = {(ADDR_W+1){1'b0}};
            seg_count_nx_s  = 16'd0;
            remain_nx_s     = 16'd0;
            overflow_nx_s   = 1'b0;
        end else begin
            word_count_nx_s = word_count_r + {{ADDR_W{1'b0}}, we_s};
            seg_count_nx_s  = seg_count_r + {15'd0, seg_done_s};
            overflow_nx_s   = overflow_r | (active_s & full_s);
            if (xfer_s && state_r == ST_HDR) begin
                remain_nx_s = strm.data[15:0];
            end else if (xfer_s) begin
                remain_nx_s = remain_r - 16'd1;
            end else begin
                remain_nx_s = remain_r;
            end
        end
        ready_nx_s = active_s & is_active(state_nx_s) & ~stall_s &
                     (word_count_nx_s != DEPTH_C);
        done_nx_s  = (state_nx_s == ST_DONE);
    end

    // counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count_r <= {(ADDR_W+1){1'b0}};
            seg_count_r  <= 16'd0;
            remain_r     <= 16'd0;
            ready_r      <= 1'b0;
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            word_count_r <= word_count_nx_s;
            seg_count_r  <= seg_count_nx_s;
            remain_r     <= remain_nx_s;
            ready_r      <= ready_nx_s;
            done_r       <= done_nx_s;
            overflow_r   <= overflow_nx_s;
        end
    end

    // capture RAM write port (contents deliberately not reset)
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[word_count_r[ADDR_W-1:0]] <= strm.data;
        end
    end

    // readback port, read-before-write
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign strm.ready = ready_r;
    assign done       = done_r;
    assign overflow   = overflow_r;
    assign word_count = word_count_r;
    assign seg_count  = seg_count_r;
    assign rd_data    = rd_data_r;

endmodule

// File: tb/tb_glb_read_sink.sv
// Bench for glb_read_sink: three instances (basic/overflow, two-segment, stalled)
// share one stimulus bus selected by sel; a scoreboard checks captured memory.
module tb_glb_read_sink;

    typedef struct {
        int          addr;
        logic [16:0] data;
    } sb_t;

    typedef struct {
        logic [16:0] data;
        int          seg;
        bit          done;
        int          wc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [16:0] data = 17'd0;
    logic        valid = 1'b0;
    logic [7:0]  rd_addr = 8'd0;
    int          sel = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          exp_addr = 0;
    int          xfer_cyc = 0;
    sb_t         sb[$];

    logic        done0, done1, done2, ovf0, ovf1, ovf2;
    logic [3:0]  wc0;
    logic [4:0]  wc1;
    logic [7:0]  wc2;
    logic [15:0] seg0, seg1, seg2;
    logic [16:0] rdd0, rdd1, rdd2;
    logic        cur_ready, cur_done, cur_ovf;
    logic [15:0] cur_wc, cur_seg;
    logic [16:0] cur_rd;

    glb_read_sink_if #(.DATA_W(17)) bus0 ();
    glb_read_sink_if #(.DATA_W(17)) bus1 ();
    glb_read_sink_if #(.DATA_W(17)) bus2 ();

    assign bus0.data  = data;
    assign bus1.data  = data;
    assign bus2.data  = data;
    assign bus0.valid = valid && (sel == 0);
    assign bus1.valid = valid && (sel == 1);
    assign bus2.valid = valid && (sel == 2);

    glb_read_sink #(.DEPTH(8), .TX_NUM(1), .STALL_EN(0), .RAN_SHIFT(0)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .strm(bus0.slave), .done(done0),
        .overflow(ovf0), .word_count(wc0), .seg_count(seg0),
        .rd_addr(rd_addr[2:0]), .rd_data(rdd0));

    glb_read_sink #(.DEPTH(16), .TX_NUM(2), .STALL_EN(0), .RAN_SHIFT(0)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .strm(bus1.slave), .done(done1),
        .overflow(ovf1), .word_count(wc1), .seg_count(seg1),
        .rd_addr(rd_addr[3:0]), .rd_data(rdd1));

    glb_read_sink #(.DEPTH(128), .TX_NUM(1), .STALL_EN(1), .RAN_SHIFT(2)) u2 (
        .clk(clk), .rst(rst), .flush(flush), .strm(bus2.slave), .done(done2),
        .overflow(ovf2), .word_count(wc2), .seg_count(seg2),
        .rd_addr(rd_addr[6:0]), .rd_data(rdd2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        cur_ready = bus0.ready; cur_done = done0; cur_ovf = ovf0;
        cur_wc = 16'(wc0); cur_seg = seg0; cur_rd = rdd0;
        case (sel)
            1: begin
                cur_ready = bus1.ready; cur_done = done1; cur_ovf = ovf1;
                cur_wc = 16'(wc1); cur_seg = seg1; cur_rd = rdd1;
            end
            2: begin
                cur_ready = bus2.ready; cur_done = done2; cur_ovf = ovf2;
                cur_wc = 16'(wc2); cur_seg = seg2; cur_rd = rdd2;
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic arm();
        @(negedge clk) flush = 1'b1;
        @(negedge clk) flush = 1'b0;
        exp_addr = 0;
        sb.delete();
    endtask

    // holds valid until ready is seen, so each word transfers exactly once
    task automatic push_word(input logic [16:0] w, input int budget,
                             output bit ok, output int waits);
        ok = 1'b0;
        waits = 0;
        data = w;
        valid = 1'b1;
        for (int i = 0; i < budget && !ok; i++) begin
            if (cur_ready) begin
                ok = 1'b1;
                sb.push_back('{addr: exp_addr, data: w});
                exp_addr++;
                xfer_cyc = cyc;
            end else begin
                waits++;
            end
            @(negedge clk);
        end
        valid = 1'b0;
    endtask

    task automatic rd(input int a, output logic [16:0] v);
        @(negedge clk) rd_addr = 8'(a);
        @(negedge clk) v = cur_rd;
    endtask

    task automatic drain();
        sb_t         e;
        logic [16:0] v;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd(e.addr, v);
            chk($sformatf("mem[%0d]", e.addr), 32'(v), 32'(e.data));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[4];
        logic [16:0] words[4];
        int          xc[4];
        bit          ok;
        int          w, stall_waits, nacc;
        logic [16:0] v;

        vecs[0] = '{17'h00000, 1, 1'b0, 1};
        vecs[1] = '{17'h00002, 1, 1'b0, 2};
        vecs[2] = '{17'h1F00F, 1, 1'b0, 3};
        vecs[3] = '{17'h00A5A, 2, 1'b1, 4};

        // reset values, checked while rst is still held
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cur_ready), 32'd0);
        chk("rst_done", 32'(cur_done), 32'd0);
        chk("rst_ovf", 32'(cur_ovf), 32'd0);
        chk("rst_wc", 32'(cur_wc), 32'd0);
        chk("rst_seg", 32'(cur_seg), 32'd0);
        chk("rst_rd", 32'(cur_rd), 32'd0);
        chk("rst_ready_u2", 32'(bus2.ready), 32'd0);
        rst = 1'b0;

        // 1: single segment {3,A,B,C} on consecutive cycles
        sel = 0;
        words[0] = 17'h00003; words[1] = 17'h1AAAA;
        words[2] = 17'h0BBBB; words[3] = 17'h1CCCC;
        arm();
        for (int i = 0; i < 4; i++) begin
            push_word(words[i], 20, ok, w);
            chk("t1_accept", 32'(ok), 32'd1);
            xc[i] = xfer_cyc;
        end
        chk("t1_consecutive", 32'(xc[3] - xc[0]), 32'd3);
        chk("t1_done", 32'(cur_done), 32'd1);
        chk("t1_ready_low", 32'(cur_ready), 32'd0);
        chk("t1_seg", 32'(cur_seg), 32'd1);
        chk("t1_wc", 32'(cur_wc), 32'd4);
        drain();

        // 4: header 20 into an 8-word memory
        arm();
        push_word(17'd20, 20, ok, w);
        chk("t4_hdr", 32'(ok), 32'd1);
        nacc = 0;
        for (int i = 0; i < 19; i++) begin
            push_word(17'(32'h100 + i), 10, ok, w);
            if (!ok) break;
            nacc++;
        end
        chk("t4_payload_accepted", 32'(nacc), 32'd7);
        chk("t4_wc", 32'(cur_wc), 32'd8);
        chk("t4_ovf", 32'(cur_ovf), 32'd1);
        chk("t4_done", 32'(cur_done), 32'd1);
        chk("t4_ready_low", 32'(cur_ready), 32'd0);
        drain();

        // 5: flush mid-payload, then a fresh {1,Z}
        arm();
        chk("t5_ovf_clear", 32'(cur_ovf), 32'd0);
        chk("t5_done_clear", 32'(cur_done), 32'd0);
        push_word(17'd5, 20, ok, w);
        push_word(17'h01111, 20, ok, w);
        push_word(17'h02222, 20, ok, w);
        chk("t5_wc_mid", 32'(cur_wc), 32'd3);
        arm();
        chk("t5_wc_flushed", 32'(cur_wc), 32'd0);
        chk("t5_seg_flushed", 32'(cur_seg), 32'd0);
        push_word(17'd1, 20, ok, w);
        push_word(17'h1D00D, 20, ok, w);
        chk("t5_done", 32'(cur_done), 32'd1);
        chk("t5_seg", 32'(cur_seg), 32'd1);
        chk("t5_wc", 32'(cur_wc), 32'd2);
        drain();

        // 6: transfer coinciding with flush rising must not write
        arm();
        for (int i = 0; i < 10 && !cur_ready; i++) @(negedge clk);
        chk("t6_ready_before", 32'(cur_ready), 32'd1);
        data = 17'h1ABCD;
        valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        valid = 1'b0;
        chk("t6_wc", 32'(cur_wc), 32'd0);
        chk("t6_ready", 32'(cur_ready), 32'd0);
        rd(0, v);
        chk("t6_mem0_kept", 32'(v), 32'h00001);

        // 2: two segments {0} and {2,X,Y}, table-driven
        sel = 1;
        arm();
        for (int i = 0; i < 4; i++) begin
            push_word(vecs[i].data, 20, ok, w);
            chk($sformatf("t2_accept%0d", i), 32'(ok), 32'd1);
            chk($sformatf("t2_seg%0d", i), 32'(cur_seg), 32'(vecs[i].seg));
            chk($sformatf("t2_done%0d", i), 32'(cur_done), 32'(vecs[i].done));
            chk($sformatf("t2_wc%0d", i), 32'(cur_wc), 32'(vecs[i].wc));
        end
        chk("t2_ready_low", 32'(cur_ready), 32'd0);
        drain();

        // 3: 100-word payload under random backpressure; header bit 16 is ignored
        sel = 2;
        arm();
        stall_waits = 0;
        push_word(17'h10064, 50, ok, w);
        chk("t3_hdr", 32'(ok), 32'd1);
        for (int i = 0; i < 100; i++) begin
            push_word(17'($urandom), 50, ok, w);
            if (!ok) begin
                chk($sformatf("t3_accept%0d", i), 32'(ok), 32'd1);
                break;
            end
            stall_waits += w;
        end
        checks++;
        if (stall_waits == 0) begin
            errors++;
            $display("FAIL t3_stall_seen: got 0 stall cycles expected >0");
        end
        chk("t3_wc", 32'(cur_wc), 32'd101);
        chk("t3_seg", 32'(cur_seg), 32'd1);
        chk("t3_done", 32'(cur_done), 32'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
